// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// Module  : mux_rr_arbiter
// Brief   : Two-requester round-robin arbiter feeding one registered W-bit slot
//           with valid/ready handshake and per-source transfer counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d0_valid,
    input  logic [W-1:0]     d0,
    output logic             d0_ack,
    input  logic             d1_valid,
    input  logic [W-1:0]     d1,
    output logic             d1_ack,
    output logic             q_valid,
    output logic [W-1:0]     q,
    output logic             q_src,
    input  logic             q_ready,
    output logic             s,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_prio;
    logic [W-1:0]     r_q;
    logic             r_q_src;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_drain;
    logic             w_cap_en;
    logic             w_grant;
    logic             w_sel;
    logic [W-1:0]     w_data;

    // Gating with rst_n keeps acks low while reset is held.
    assign w_drain  = (r_state == ST_FULL) & q_ready;
    assign w_cap_en = rst_n & ((r_state == ST_EMPTY) | q_ready);
    assign w_grant  = w_cap_en & (d0_valid | d1_valid);
    assign w_sel    = (d0_valid & d1_valid) ? r_prio : d1_valid;
    assign w_data   = w_sel ? d1 : d0;

    assign s      = w_grant & w_sel;
    assign d0_ack = w_grant & ~w_sel;
    assign d1_ack = w_grant & w_sel;

    assign q_valid = (r_state == ST_FULL);
    assign q       = r_q;
    assign q_src   = r_q_src;
    assign cnt0    = r_cnt0;
    assign cnt1    = r_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_prio  <= 1'b0;
            r_q     <= '0;
            r_q_src <= 1'b0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_grant) r_state <= ST_FULL;
                ST_FULL:  if (q_ready && !w_grant) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase

            if (w_grant) begin
                r_q     <= w_data;
                r_q_src <= w_sel;
                r_prio  <= ~w_sel;
            end

            if (w_drain) begin
                if (r_q_src) r_cnt1 <= r_cnt1 + 1'b1;
                else         r_cnt0 <= r_cnt0 + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ============================================================================
// Module  : tb_mux_rr_arbiter
// Brief   : Directed self-checking bench for mux_rr_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             d0_valid, d1_valid;
    logic [W-1:0]     d0, d1;
    logic             d0_ack, d1_ack;
    logic             q_valid, q_src, q_ready, s;
    logic [W-1:0]     q;
    logic [CNT_W-1:0] cnt0, cnt1;

    int n_vec = 0;
    int n_err = 0;

    mux_rr_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d0_valid (d0_valid),
        .d0       (d0),
        .d0_ack   (d0_ack),
        .d1_valid (d1_valid),
        .d1       (d1),
        .d1_ack   (d1_ack),
        .q_valid  (q_valid),
        .q        (q),
        .q_src    (q_src),
        .q_ready  (q_ready),
        .s        (s),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        d0_valid = 1'b0;
        d1_valid = 1'b0;
        d0       = '0;
        d1       = '0;
        q_ready  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset then idle
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("idle_qvalid", q_valid, 0);
        chk("idle_ack0", d0_ack, 0);
        chk("idle_ack1", d1_ack, 0);
        chk("idle_cnt0", cnt0, 0);
        chk("idle_cnt1", cnt1, 0);
        chk("idle_s", s, 0);

        // 2: single requester
        d0_valid = 1'b1; d0 = 4'hA; q_ready = 1'b1;
        #1;
        chk("single_ack0", d0_ack, 1);
        chk("single_s", s, 0);
        step();
        d0_valid = 1'b0;
        chk("single_q", q, 4'hA);
        chk("single_src", q_src, 0);
        chk("single_qvalid", q_valid, 1);
        chk("single_cnt0_pre", cnt0, 0);
        step();
        chk("single_cnt0", cnt0, 1);
        chk("single_empty", q_valid, 0);

        // 3: contention, starting from a fresh pointer
        do_reset();
        d0_valid = 1'b1; d0 = 4'h3;
        d1_valid = 1'b1; d1 = 4'hC;
        q_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_s", s, i % 2);
            chk("cont_acks_excl", d0_ack & d1_ack, 0);
            chk("cont_ack_any", d0_ack | d1_ack, 1);
            step();
            chk("cont_q", q, (i % 2) ? 4'hC : 4'h3);
        end
        d0_valid = 1'b0; d1_valid = 1'b0;
        step();
        chk("cont_cnt0", cnt0, 3);
        chk("cont_cnt1", cnt1, 3);
        chk("cont_drained", q_valid, 0);

        // 4: backpressure
        q_ready = 1'b0; d0_valid = 1'b1; d0 = 4'h5;
        #1;
        chk("bp_ack0", d0_ack, 1);
        step();
        d0_valid = 1'b0; d1_valid = 1'b1; d1 = 4'h9;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_hold_ack1", d1_ack, 0);
            chk("bp_hold_q", q, 4'h5);
            chk("bp_hold_qvalid", q_valid, 1);
            step();
        end
        q_ready = 1'b1;
        #1;
        chk("bp_release_ack1", d1_ack, 1);
        chk("bp_release_s", s, 1);
        step();
        d1_valid = 1'b0;
        chk("bp_q_next", q, 4'h9);
        chk("bp_src_next", q_src, 1);
        chk("bp_no_bubble", q_valid, 1);
        chk("bp_cnt0", cnt0, 4);
        step();
        chk("bp_cnt1", cnt1, 4);
        chk("bp_empty", q_valid, 0);

        // 5: asynchronous reset mid-operation (pointer is 1 just before reset)
        q_ready = 1'b0; d0_valid = 1'b1; d0 = 4'h7;
        step();
        d0_valid = 1'b0;
        chk("mid_q_pre", q, 4'h7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_qvalid", q_valid, 0);
        chk("mid_rst_q", q, 0);
        chk("mid_rst_cnt0", cnt0, 0);
        chk("mid_rst_cnt1", cnt1, 0);
        d0_valid = 1'b1; d0 = 4'h2;
        d1_valid = 1'b1; d1 = 4'hE;
        q_ready  = 1'b1;
        #1;
        chk("mid_rst_ack_gated", d0_ack | d1_ack, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_after_ack0", d0_ack, 1);
        chk("mid_after_ack1", d1_ack, 0);
        step();
        d0_valid = 1'b0;
        chk("mid_q0", q, 4'h2);
        chk("mid_src0", q_src, 0);
        chk("mid_ack1", d1_ack, 1);
        step();
        d1_valid = 1'b0;
        chk("mid_q1", q, 4'hE);
        chk("mid_src1", q_src, 1);
        step();

        // 6: counter wrap on requester 1
        do_reset();
        d1_valid = 1'b1; d1 = 4'h6; q_ready = 1'b1;
        for (int i = 0; i < 256; i++) step();
        chk("wrap_cnt1_255", cnt1, 255);
        d1_valid = 1'b0;
        step();
        chk("wrap_cnt1_0", cnt1, 0);
        chk("wrap_cnt0", cnt0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares a single W-bit output channel.
- Generates the 2:1 select for the shared data mux and captures the selected word into a registered output slot with a valid/ready handshake.
- Sits between two producer blocks and one consumer.
- Provides per-source transfer counters for lab/debug readout.

Parameters:
- W, 4, data width of each requester and of the output
- CNT_W, 8, width of each per-source transfer counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- d0_valid  input  1  requester 0 has a word on d0
- d0  input  W  requester 0 data
- d0_ack  output  1  one-cycle pulse: d0 captured this edge
- d1_valid  input  1  requester 1 has a word on d1
- d1  input  W  requester 1 data
- d1_ack  output  1  one-cycle pulse: d1 captured this edge
- q_valid  output  1  output slot holds a word
- q  output  W  output data (registered)
- q_src  output  1  source of the word in q (0 = d0, 1 = d1)
- q_ready  input  1  consumer accepts q this cycle
- s  output  1  mux select used for the current capture (combinational, valid when a grant occurs)
- cnt0  output  CNT_W  number of words accepted from requester 0
- cnt1  output  CNT_W  number of words accepted from requester 1

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - q_valid=0, q=0, q_src=0, d0_ack=0, d1_ack=0, cnt0=0, cnt1=0.
  - Priority pointer prio=0 (requester 0 favoured); FSM=EMPTY.
  - A word captured but not yet accepted is discarded. Its requester was already acked; recovery is the system's responsibility.
- Requester rule: dk_valid and dk stay stable until dk_ack pulses. dk_valid may drop only after ack.
- Slot FSM, states EMPTY and FULL:
  - EMPTY: capture allowed. Grant occurs if any dk_valid; next state FULL, else stay EMPTY.
  - FULL: q_valid=1. If q_ready, the slot drains this cycle and a capture is also allowed on the same edge.
    - Capture on drain: stay FULL. No capture on drain: go to EMPTY.
    - If q_ready=0: hold q, q_src, no grant.
- Grant selection (combinational, only when capture allowed):
  - Only d0_valid: grant 0. Only d1_valid: grant 1.
  - Both valid: grant prio.
  - s = granted index (s=0 when no grant).
- On a grant to k at an edge:
  - q<=dk; q_src<=k; q_valid<=1; dk_ack pulses high in the cycle the grant is computed (same cycle as the capturing edge); prio<=~k.
- Latency: a word presented to an empty slot appears on q one cycle later. Throughput is one word per cycle with q_ready held high.
- Fairness: under continuous contention, grants alternate 0,1,0,1. Neither requester waits more than one transfer.
- Counters:
  - cnt0/cnt1 increment when a word with q_src=0/1 is accepted (q_valid & q_ready).
  - They wrap modulo 2^CNT_W; 255+1 -> 0 for CNT_W=8.
- At most one ack per cycle; d0_ack & d1_ack is never 1.
- q changes only on capture; it must be stable while q_valid & ~q_ready.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, release, no valids for 5 cycles -> q_valid=0, acks 0, cnt0=cnt1=0, s=0.
2. Single requester: d0_valid=1, d0=4'hA, q_ready=1 -> d0_ack pulses cycle 0; q=4'hA, q_src=0, q_valid=1 cycle 1; cnt0=1 after acceptance.
3. Contention: both valid continuously, d0=4'h3, d1=4'hC, q_ready=1 for 6 cycles -> q sequence 3,C,3,C,3,C; cnt0=3, cnt1=3; never both acks.
4. Backpressure: slot FULL with q=4'h5, q_ready=0 for 4 cycles while d1_valid=1 -> q stays 5, d1_ack stays 0. Raise q_ready -> d1 captured that edge, q=d1 next cycle, no bubble.
5. Reset mid-operation: slot FULL with q=4'h7, assert rst_n low between clock edges -> q_valid, q, counters immediately 0. After release with d1_valid=1 pending, d0_valid=1, d1 is held until d0 is served first (prio=0).
6. Counter wrap: force 256 accepted transfers from requester 1 -> cnt1 returns to 0, cnt0 unchanged.
